risc_kgp_seq_ctrl: RTL and testbench
====================================

// Module: risc_kgp_seq_ctrl
// PURPOSE
//  Multi-cycle phase sequencer for the RISC-KGP datapath. Replaces free-running clka/clkb phasing with explicit
//  per-phase enables: FETCH -> DECODE -> EXEC -> MEM -> WB. Sits beside Control; gates PC, IR, RF, ALU, data memory.
//  Stalls on data-memory handshake, stops on halt opcode or external halt request.
// PARAMETERS
//  IMEM_LAT     2        cycles from imem_en to instruction valid (1..15)
//  HALT_OPCODE  5'h1F    opcode (instr[31:27]) that stops the sequencer
//  CNT_W        32       width of retired-instruction counter
//  TIMEOUT_CYC  64       mem_ready wait limit (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1      single core clock
//  reset        in   1      asynchronous, active-high
//  run          in   1      level; start/resume from IDLE
//  halt_req     in   1      external stop request, sampled at WB
//  opcode       in   5      instr[31:27], valid from DECODE onward
//  mem_rd       in   1      MemRead from Control
//  mem_wr       in   1      MemWrite from Control
//  mem_ready    in   1      data memory completion, 1-cycle pulse or level
//  imem_en      out  1      instruction-memory enable
//  ir_load      out  1      latch instruction register
//  alu_en       out  1      ALU operand/result register enable
//  dmem_en      out  1      data-memory enable (qualifies MemRead/MemWrite)
//  rf_we_gate   out  1      AND-ed with RegWrite; write only in WB
//  pc_we        out  1      load next_pc into ProgramCounter
//  busy         out  1      not IDLE and not HALT
//  halted       out  1      in HALT
//  err          out  1      sticky memory-timeout error
//  retired      out  CNT_W  instructions completed
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, retired=0, err=0. Outputs are registered.
//  IDLE: run=1 -> FETCH (imem_en=1 that cycle, wait counter loaded IMEM_LAT-1).
//  FETCH: imem_en held; counter decrements; at 0, ir_load=1 for one cycle -> DECODE. Total IMEM_LAT+1 cycles.
//  DECODE: one cycle. opcode==HALT_OPCODE -> HALT (no pc_we, retired unchanged); else -> EXEC.
//  EXEC: alu_en=1 one cycle. mem_rd|mem_wr -> MEM; else -> WB.
//  MEM: dmem_en=1 until mem_ready sampled 1; mem_ready asserted on first MEM cycle -> 1-cycle MEM.
//   mem_ready outside MEM ignored. mem_rd and mem_wr both 1 is illegal: treat as write.
//  WB: rf_we_gate=1, pc_we=1 for exactly one cycle; retired+=1 (wraps modulo 2^CNT_W, no flag).
//   Then halt_req=1 -> HALT; run=0 -> IDLE; else -> FETCH.
//  HALT: all enables 0, halted=1. Leaves only on reset. run ignored.
//  halt_req mid-instruction: current instruction completes through WB, then HALT. Never abandons a store.
//  At most one of ir_load, alu_en, rf_we_gate/pc_we asserted per cycle; enables never overlap phases.
//  Reset mid-MEM: dmem_en drops asynchronously; memory side must tolerate truncated access.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: counter in MEM; TIMEOUT_CYC cycles without mem_ready -> err=1 (sticky), HALT,
//   no WB, retired unchanged.
//  SEQ_TIMEOUT_EN undefined: MEM waits indefinitely; err tied 0; TIMEOUT_CYC unused.
// STRUCTURE
//  Package risc_kgp_seq_pkg: state enum (IDLE,FETCH,DECODE,EXEC,MEM,WB,HALT), default HALT opcode,
//   phase-enable bit positions.
//  Sub-module risc_kgp_wait_cnt: loadable down-counter with zero flag, shared by FETCH latency and MEM timeout.
//  Top: one registered FSM plus output decode; no combinational paths from inputs to outputs.
// TESTING
//  ALU instr, IMEM_LAT=2, run=1 -> ir_load at cycle 3, alu_en 5, rf_we_gate/pc_we 6, retired=1, FETCH at 7.
//  Load, mem_ready after 3 MEM cycles -> dmem_en high exactly 3 cycles, WB follows, retired increments once.
//  opcode=5'h1F in DECODE -> halted=1 next cycle, pc_we never asserted, retired unchanged; run toggling ignored.
//  halt_req pulse during EXEC of a store -> MEM completes, WB occurs, then HALT; retired includes the store.
//  reset asserted mid-MEM -> all outputs 0 same cycle, retired=0; after release + run, FETCH resumes.
//  SEQ_TIMEOUT_EN, TIMEOUT_CYC=64, mem_ready stuck 0 -> err=1 and HALT after 64 MEM cycles; CNT_W=4 wrap 15->0.

Source files
------------

// File: rtl/risc_kgp_seq_pkg.sv
// ---------------------------------------------------------------------------
// risc_kgp_seq_pkg
// Shared definitions for the RISC-KGP multi-cycle phase sequencer:
//   - seq_state_e   : sequencer state encoding
//   - DEFAULT_HALT_OPCODE : opcode (instr[31:27]) that stops the sequencer
//   - PH_*          : bit positions of the per-phase enables in the internal
//                     enable vector
//   - max_int       : elaboration-time helper for counter sizing
//   - phase_enables : maps a state to the enables that are active in it
// ---------------------------------------------------------------------------
package risc_kgp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } seq_state_e;

    localparam logic [4:0] DEFAULT_HALT_OPCODE = 5'h1F;

    // Phase-enable bit positions
    localparam int PH_IMEM = 0;
    localparam int PH_IR   = 1;
    localparam int PH_ALU  = 2;
    localparam int PH_DMEM = 3;
    localparam int PH_RF   = 4;
    localparam int PH_PC   = 5;
    localparam int PH_NUM  = 6;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // ir_flag marks the last FETCH cycle, where the instruction is latched.
    function automatic logic [PH_NUM-1:0] phase_enables(input seq_state_e st,
                                                        input logic       ir_flag);
        logic [PH_NUM-1:0] en;
        en = '0;
        case (st)
            FETCH: begin
                en[PH_IMEM] = 1'b1;
                en[PH_IR]   = ir_flag;
            end
            EXEC:    en[PH_ALU]  = 1'b1;
            MEM:     en[PH_DMEM] = 1'b1;
            WB: begin
                en[PH_RF] = 1'b1;
                en[PH_PC] = 1'b1;
            end
            default: en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/risc_kgp_wait_cnt.sv
// ---------------------------------------------------------------------------
// risc_kgp_wait_cnt
// Loadable down-counter with zero flag. Used by the sequencer both for the
// instruction-memory latency in FETCH and for the data-memory timeout in MEM.
// Ports:
//   clk      in  core clock
//   reset    in  asynchronous, active-high; clears the count
//   load     in  load load_val (has priority over dec)
//   load_val in  W-bit value to load
//   dec      in  decrement by one; saturates at zero
//   zero     out count is zero
// ---------------------------------------------------------------------------
module risc_kgp_wait_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/risc_kgp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// risc_kgp_seq_ctrl
// Multi-cycle phase sequencer for the RISC-KGP datapath:
//   IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH/IDLE/HALT
// Every output is a flop loaded from the decode of the next state, so there
// is no combinational path from any input to any output.
// Optional feature: define SEQ_TIMEOUT_EN to enable the MEM-phase timeout
// (TIMEOUT_CYC cycles without mem_ready -> sticky err and HALT without WB).
// Without it MEM waits indefinitely and err stays 0.
// Ports:
//   clk, reset (async, active-high)
//   run        level start/resume from IDLE
//   halt_req   external stop; honoured after the current instruction's WB
//   opcode     instr[31:27], sampled in DECODE
//   mem_rd/mem_wr  Control's MemRead/MemWrite, sampled in EXEC
//   mem_ready  data-memory completion, only observed in MEM
//   imem_en, ir_load, alu_en, dmem_en, rf_we_gate, pc_we  phase enables
//   busy, halted, err, retired[CNT_W]                     status
// ---------------------------------------------------------------------------
module risc_kgp_seq_ctrl
    import risc_kgp_seq_pkg::*;
#(
    parameter int         IMEM_LAT    = 2,
    parameter logic [4:0] HALT_OPCODE = DEFAULT_HALT_OPCODE,
    parameter int         CNT_W       = 32,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic [4:0]       opcode,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic             mem_ready,
    output logic             imem_en,
    output logic             ir_load,
    output logic             alu_en,
    output logic             dmem_en,
    output logic             rf_we_gate,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    localparam int                WAIT_W     = $clog2(max_int(IMEM_LAT, TIMEOUT_CYC) + 1);
    localparam logic [WAIT_W-1:0] FETCH_LOAD = WAIT_W'(IMEM_LAT - 1);
    localparam logic [WAIT_W-1:0] MEM_LOAD   = WAIT_W'(TIMEOUT_CYC - 1);

    seq_state_e        state_q, state_d;
    logic              ir_flag_q, ir_flag_d;
    logic              halt_pend_q, halt_pend_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [PH_NUM-1:0] en_q, en_d;

    logic              cnt_load;
    logic [WAIT_W-1:0] cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    risc_kgp_wait_cnt #(
        .W (WAIT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        ir_flag_d    = 1'b0;
        halt_pend_d  = halt_pend_q;
        err_d        = err_q;
        retired_d    = retired_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d      = FETCH;
                    cnt_load     = 1'b1;
                    cnt_load_val = FETCH_LOAD;
                end
            end
            FETCH: begin
                // Count the memory latency down, then spend one extra
                // cycle with ir_load high before moving on.
                if (ir_flag_q) begin
                    state_d = DECODE;
                end else if (cnt_zero) begin
                    ir_flag_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DECODE: begin
                state_d = (opcode == HALT_OPCODE) ? HALT : EXEC;
            end
            EXEC: begin
                // mem_rd & mem_wr together is treated as a write; both take
                // the same MEM path, so no distinction is needed here.
                if (mem_rd || mem_wr) begin
                    state_d      = MEM;
                    cnt_load     = 1'b1;
                    cnt_load_val = MEM_LOAD;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    state_d = WB;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (cnt_zero) begin
                    state_d = HALT;
                    err_d   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            WB: begin
                if (halt_req || halt_pend_q) begin
                    state_d = HALT;
                end else if (!run) begin
                    state_d = IDLE;
                end else begin
                    state_d      = FETCH;
                    cnt_load     = 1'b1;
                    cnt_load_val = FETCH_LOAD;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Remember a halt request seen mid-instruction so it takes effect
        // only after the instruction has written back.
        if (halt_req && busy_q) begin
            halt_pend_d = 1'b1;
        end

        // WB lasts exactly one cycle, so counting WB entries counts retires.
        if (state_d == WB) begin
            retired_d = retired_q + CNT_W'(1);
        end

        en_d     = phase_enables(state_d, ir_flag_d);
        busy_d   = (state_d != IDLE) && (state_d != HALT);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ir_flag_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_flag_q   <= ir_flag_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    // One flop per phase enable
    genvar gi;
    generate
        for (gi = 0; gi < PH_NUM; gi++) begin : g_en
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    en_q[gi] <= 1'b0;
                end else begin
                    en_q[gi] <= en_d[gi];
                end
            end
        end
    endgenerate

    assign imem_en    = en_q[PH_IMEM];
    assign ir_load    = en_q[PH_IR];
    assign alu_en     = en_q[PH_ALU];
    assign dmem_en    = en_q[PH_DMEM];
    assign rf_we_gate = en_q[PH_RF];
    assign pc_we      = en_q[PH_PC];
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_risc_kgp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_risc_kgp_seq_ctrl
// Scoreboard bench for risc_kgp_seq_ctrl (IMEM_LAT=2, CNT_W=4).
// Stimulus pushes expected events (ir_load, alu_en, WB, HALT entry) with the
// expected cycle distance from the previous event; a monitor pops and checks
// them whenever the DUT presents the corresponding output.
// Build with SEQ_TIMEOUT_EN defined to exercise the MEM timeout.
// ---------------------------------------------------------------------------
module tb_risc_kgp_seq_ctrl;

    localparam int K_IR   = 0;
    localparam int K_ALU  = 1;
    localparam int K_WB   = 2;
    localparam int K_HALT = 3;

    typedef struct {
        int         kind;
        int         dly;
        logic [3:0] ret;
        int         mlen;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       halt_req;
    logic [4:0] opcode;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_ready;
    logic       imem_en, ir_load, alu_en, dmem_en, rf_we_gate, pc_we;
    logic       busy, halted, err;
    logic [3:0] retired;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         dmem_cnt = 0;
    logic       halted_prev = 1'b0;
    logic [3:0] ret_model = 4'd0;
    exp_t       exp_q[$];

    risc_kgp_seq_ctrl #(
        .IMEM_LAT    (2),
        .HALT_OPCODE (5'h1F),
        .CNT_W       (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_req   (halt_req),
        .opcode     (opcode),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_ready  (mem_ready),
        .imem_en    (imem_en),
        .ir_load    (ir_load),
        .alu_en     (alu_en),
        .dmem_en    (dmem_en),
        .rf_we_gate (rf_we_gate),
        .pc_we      (pc_we),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_IR:    return "ir_load";
            K_ALU:   return "alu_en";
            K_WB:    return "wb";
            default: return "halt";
        endcase
    endfunction

    function automatic logic sig(input int which);
        case (which)
            K_IR:    return ir_load;
            K_ALU:   return alu_en;
            K_WB:    return pc_we;
            default: return halted;
        endcase
    endfunction

    task automatic push(input int kind, input int dly, input logic [3:0] ret,
                        input int mlen, input logic e);
        exp_t x;
        x.kind = kind; x.dly = dly; x.ret = ret; x.mlen = mlen; x.err = e;
        exp_q.push_back(x);
    endtask

    // Monitor: pop and compare one expectation per observed event
    task automatic observe(input int kind);
        exp_t x;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: seen at cycle %0d, required none", kname(kind), cyc);
        end else begin
            x = exp_q.pop_front();
            if (x.kind != kind || (cyc - last_cyc) != x.dly) begin
                errors++;
                $display("FAIL seq_%s: got %s after %0d cycles, required %s after %0d",
                         kname(x.kind), kname(kind), cyc - last_cyc, kname(x.kind), x.dly);
            end else begin
                $display("event %-8s cycle %0d retired=%0d dmem=%0d err=%0b",
                         kname(kind), cyc, retired, dmem_cnt, err);
            end
            if (kind == K_WB) begin
                checks++;
                if (retired !== x.ret || dmem_cnt != x.mlen || rf_we_gate !== 1'b1 || err !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_state: retired=%0d dmem=%0d rf_we=%b err=%b, required %0d %0d 1 0",
                             retired, dmem_cnt, rf_we_gate, err, x.ret, x.mlen);
                end
            end
            if (kind == K_HALT) begin
                checks++;
                if (retired !== x.ret || err !== x.err || busy !== 1'b0 ||
                    {imem_en, ir_load, alu_en, dmem_en, rf_we_gate, pc_we} !== 6'b0) begin
                    errors++;
                    $display("FAIL halt_state: retired=%0d err=%b busy=%b en=%b, required %0d %b 0 000000",
                             retired, err, busy, {imem_en, ir_load, alu_en, dmem_en, rf_we_gate, pc_we},
                             x.ret, x.err);
                end
            end
        end
        last_cyc = cyc;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            dmem_cnt    = 0;
            halted_prev = 1'b0;
        end else begin
            if (dmem_en) dmem_cnt++;
            if ((int'(ir_load) + int'(alu_en) + int'(pc_we)) > 1) begin
                checks++;
                errors++;
                $display("FAIL overlap: ir=%b alu=%b pc_we=%b at cycle %0d, required at most one",
                         ir_load, alu_en, pc_we, cyc);
            end
            if (ir_load) begin
                observe(K_IR);
                dmem_cnt = 0;
            end
            if (alu_en) observe(K_ALU);
            if (pc_we) begin
                observe(K_WB);
                dmem_cnt = 0;
            end
            if (halted && !halted_prev) observe(K_HALT);
            halted_prev = halted;
        end
    end

    task automatic wait_for(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: not seen within 200 cycles, required asserted", kname(which));
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if ({imem_en, ir_load, alu_en, dmem_en, rf_we_gate, pc_we, busy, halted, err} !== 9'b0 ||
            retired !== 4'd0) begin
            errors++;
            $display("FAIL %s: outs=%b retired=%0d, required all 0",
                     nm, {imem_en, ir_load, alu_en, dmem_en, rf_we_gate, pc_we, busy, halted, err}, retired);
        end else begin
            $display("reset %s: all outputs 0", nm);
        end
    endtask

    task automatic start_run();
        run      = 1'b1;
        last_cyc = cyc;
    endtask

    task automatic apply_reset(input string nm);
        @(negedge clk);
        run = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero(nm);
        @(negedge clk);
        reset     = 1'b0;
        ret_model = 4'd0;
    endtask

    // One instruction: drives opcode/mem controls as the phases appear and
    // plays a data memory answering on the mlen-th MEM cycle.
    task automatic do_instr(input logic [4:0] op, input logic rd, input logic wr,
                            input int mlen, input bit hreq, input bit drop_run,
                            input bit ready_noise);
        bit ok;
        mem_ready = ready_noise;
        push(K_IR, 3, 4'd0, 0, 1'b0);
        wait_for(K_IR, ok);
        if (!ok) return;
        opcode = op;
        mem_rd = rd;
        mem_wr = wr;
        if (op == 5'h1F) begin
            push(K_HALT, 2, ret_model, 0, 1'b0);
            wait_for(K_HALT, ok);
            mem_ready = 1'b0;
            return;
        end
        push(K_ALU, 2, 4'd0, 0, 1'b0);
        wait_for(K_ALU, ok);
        if (!ok) return;
        if (hreq) halt_req = 1'b1;
        if (drop_run) run = 1'b0;
        ret_model = ret_model + 4'd1;
        push(K_WB, (rd || wr) ? 1 + mlen : 1, ret_model, (rd || wr) ? mlen : 0, 1'b0);
        @(negedge clk);
        halt_req  = 1'b0;
        mem_ready = 1'b0;
        if (rd || wr) begin
            for (int j = 1; j <= mlen; j++) begin
                mem_ready = (j == mlen);
                @(negedge clk);
            end
            mem_ready = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; opcode = 5'h0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("initial");
        reset = 1'b0;
        @(negedge clk);

        // ALU (mem_ready noise ignored), load 3, store 1, rd&wr 2, ALU to IDLE
        start_run();
        do_instr(5'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        do_instr(5'h02, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        do_instr(5'h03, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        do_instr(5'h04, 1'b1, 1'b1, 2, 1'b0, 1'b0, 1'b0);
        do_instr(5'h05, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || imem_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_run0: busy=%b halted=%b imem_en=%b, required 0 0 0", busy, halted, imem_en);
        end else begin
            $display("idle after run=0: busy=0 halted=0");
        end

        // 11 ALU instructions: retired 6..15 then wraps to 0
        start_run();
        for (int i = 0; i < 11; i++) do_instr(5'h06, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Store with halt_req pulse in EXEC: completes, writes back, halts
        do_instr(5'h07, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        push(K_HALT, 1, ret_model, 0, 1'b0);
        wait_for(K_HALT, ok);
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            @(negedge clk);
        end
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || retired !== ret_model) begin
            errors++;
            $display("FAIL halt_sticky: halted=%b busy=%b retired=%0d, required 1 0 %0d",
                     halted, busy, retired, ret_model);
        end else begin
            $display("halt sticky under run toggling: retired=%0d", retired);
        end
        apply_reset("from_halt");

        // HALT opcode: no WB, retired unchanged
        @(negedge clk);
        start_run();
        do_instr(5'h1F, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            @(negedge clk);
        end
        checks++;
        if (halted !== 1'b1 || retired !== 4'd0 || pc_we !== 1'b0) begin
            errors++;
            $display("FAIL halt_opcode: halted=%b retired=%0d pc_we=%b, required 1 0 0", halted, retired, pc_we);
        end else begin
            $display("halt opcode: halted=1 retired=0");
        end
        apply_reset("after_halt_op");

        // Reset in the middle of a load's MEM phase
        @(negedge clk);
        start_run();
        do_instr(5'h08, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        push(K_IR, 3, 4'd0, 0, 1'b0);
        wait_for(K_IR, ok);
        opcode = 5'h09;
        mem_rd = 1'b1;
        push(K_ALU, 2, 4'd0, 0, 1'b0);
        wait_for(K_ALU, ok);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero("mid_mem");
        @(negedge clk);
        mem_rd    = 1'b0;
        ret_model = 4'd0;
        reset     = 1'b0;
        last_cyc  = cyc;
        do_instr(5'h0A, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_TIMEOUT_EN
        // mem_ready stuck low: 64 MEM cycles, then err and HALT without WB
        push(K_IR, 3, 4'd0, 0, 1'b0);
        wait_for(K_IR, ok);
        opcode = 5'h0B;
        mem_rd = 1'b1;
        push(K_ALU, 2, 4'd0, 0, 1'b0);
        wait_for(K_ALU, ok);
        mem_ready = 1'b0;
        push(K_HALT, 65, ret_model, 0, 1'b1);
        wait_for(K_HALT, ok);
`else
        // Long MEM wait: no timeout, WB after 70 cycles, err stays 0
        do_instr(5'h0B, 1'b1, 1'b0, 70, 1'b0, 1'b1, 1'b0);
`endif
        repeat (4) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected events not seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
